// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared core-side memory bus: instruction fetch vs load/store.
// Load/store has fixed priority, bounded by a starvation guard that forces a fetch grant.
package common;
  parameter int XLEN = 64;
endpackage

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = common::XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [XLEN-1:0]   ireq_addr,
  output logic              iresp_ready,
  output logic [XLEN-1:0]   iresp_data,
  input  logic              dreq_valid,
  input  logic              dreq_is_write,
  input  logic [2:0]        dreq_size,
  input  logic [XLEN-1:0]   dreq_addr,
  input  logic [XLEN/8-1:0] dreq_strobe,
  input  logic [XLEN-1:0]   dreq_data,
  output logic              dresp_ready,
  output logic [XLEN-1:0]   dresp_data,
  output logic              bus_valid,
  output logic              bus_is_write,
  output logic [2:0]        bus_size,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_strobe,
  output logic [XLEN-1:0]   bus_data,
  input  logic              bus_resp_ready,
  input  logic [XLEN-1:0]   bus_resp_data,
  output logic              grant_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e              state_q, state_d;
  logic                is_write_q, is_write_d;
  logic [2:0]          size_q, size_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN/8-1:0]   strobe_q, strobe_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic                pick_ireq;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    is_write_d  = is_write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    strobe_d    = strobe_q;
    data_d      = data_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    pick_ireq   = 1'b0;
    iresp_ready = 1'b0;
    dresp_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          pick_ireq = ireq_valid && (!dreq_valid || starve_q == LIMIT);
          state_d   = BUSY;
          owner_d   = !pick_ireq;
          if (pick_ireq) begin
            is_write_d = 1'b0;
            size_d     = 3'd3;
            addr_d     = ireq_addr;
            strobe_d   = '0;
            data_d     = '0;
            starve_d   = '0;
          end else begin
            is_write_d = dreq_is_write;
            size_d     = dreq_size;
            addr_d     = dreq_addr;
            strobe_d   = dreq_strobe;
            data_d     = dreq_data;
            // Only a grant that actually made fetch wait counts toward starvation.
            if (ireq_valid && starve_q != LIMIT) starve_d = starve_q + 4'd1;
          end
        end
      end
      BUSY: begin
        if (bus_resp_ready) begin
          iresp_ready = !owner_q;
          dresp_ready = owner_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      strobe_q   <= '0;
      data_q     <= '0;
      owner_q    <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
    end
  end

  assign bus_valid    = (state_q == BUSY);
  assign bus_is_write = is_write_q;
  assign bus_size     = size_q;
  assign bus_addr     = addr_q;
  assign bus_strobe   = strobe_q;
  assign bus_data     = data_q;
  assign grant_d      = owner_q;
  assign iresp_data   = bus_resp_data;
  assign dresp_data   = bus_resp_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, contention, starvation guard, stability, reset, spurious response.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ready;
  logic [63:0] iresp_data;
  logic        dreq_valid;
  logic        dreq_is_write;
  logic [2:0]  dreq_size;
  logic [63:0] dreq_addr;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ready;
  logic [63:0] dresp_data;
  logic        bus_valid;
  logic        bus_is_write;
  logic [2:0]  bus_size;
  logic [63:0] bus_addr;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_data;
  logic        bus_resp_ready;
  logic [63:0] bus_resp_data;
  logic        grant_d;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_ready    (iresp_ready),
    .iresp_data     (iresp_data),
    .dreq_valid     (dreq_valid),
    .dreq_is_write  (dreq_is_write),
    .dreq_size      (dreq_size),
    .dreq_addr      (dreq_addr),
    .dreq_strobe    (dreq_strobe),
    .dreq_data      (dreq_data),
    .dresp_ready    (dresp_ready),
    .dresp_data     (dresp_data),
    .bus_valid      (bus_valid),
    .bus_is_write   (bus_is_write),
    .bus_size       (bus_size),
    .bus_addr       (bus_addr),
    .bus_strobe     (bus_strobe),
    .bus_data       (bus_data),
    .bus_resp_ready (bus_resp_ready),
    .bus_resp_data  (bus_resp_data),
    .grant_d        (grant_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is inside an IDLE cycle with the request valids already driven.
  task automatic run_txn(input string tag, input logic exp_owner, input logic [63:0] rdata);
    @(negedge clk);
    check({tag, "_idle_bv"}, bus_valid, 1'b0);
    step();
    @(negedge clk);
    check({tag, "_bv"}, bus_valid, 1'b1);
    check({tag, "_grant"}, grant_d, exp_owner);
    step();
    bus_resp_ready = 1'b1;
    bus_resp_data  = rdata;
    @(negedge clk);
    check({tag, "_iresp"}, iresp_ready, !exp_owner);
    check({tag, "_dresp"}, dresp_ready, exp_owner);
    check({tag, "_rdata"}, exp_owner ? dresp_data : iresp_data, rdata);
    step();
    bus_resp_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    ireq_valid     = 1'b0;
    ireq_addr      = '0;
    dreq_valid     = 1'b0;
    dreq_is_write  = 1'b0;
    dreq_size      = '0;
    dreq_addr      = '0;
    dreq_strobe    = '0;
    dreq_data      = '0;
    bus_resp_ready = 1'b1;
    bus_resp_data  = 64'h1234;

    // Reset state, with a response strobe present that must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bv", bus_valid, 1'b0);
    check("rst_grant", grant_d, 1'b0);
    check("rst_addr", bus_addr, 64'h0);
    check("rst_data", bus_data, 64'h0);
    check("rst_iresp", iresp_ready, 1'b0);
    check("rst_dresp", dresp_ready, 1'b0);
    step();
    reset          = 1'b0;
    bus_resp_ready = 1'b0;

    // Single fetch, response three cycles after bus_valid.
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    @(negedge clk);
    check("t1_lat_bv", bus_valid, 1'b0);
    step();
    @(negedge clk);
    check("t1_bv", bus_valid, 1'b1);
    check("t1_addr", bus_addr, 64'h8000_0000);
    check("t1_wr", bus_is_write, 1'b0);
    check("t1_size", bus_size, 3'd3);
    check("t1_grant", grant_d, 1'b0);
    step();
    step();
    @(negedge clk);
    check("t1_hold_bv", bus_valid, 1'b1);
    step();
    bus_resp_ready = 1'b1;
    bus_resp_data  = 64'h0000_0013_0000_0093;
    @(negedge clk);
    check("t1_iresp", iresp_ready, 1'b1);
    check("t1_idata", iresp_data, 64'h0000_0013_0000_0093);
    check("t1_dresp", dresp_ready, 1'b0);
    step();
    bus_resp_ready = 1'b0;
    ireq_valid     = 1'b0;
    @(negedge clk);
    check("t1_done_bv", bus_valid, 1'b0);

    // Simultaneous requests: store first, then fetch two cycles after its response.
    step();
    ireq_valid    = 1'b1;
    ireq_addr     = 64'h8000_0040;
    dreq_valid    = 1'b1;
    dreq_is_write = 1'b1;
    dreq_size     = 3'd2;
    dreq_addr     = 64'h8000_1000;
    dreq_strobe   = 8'h0F;
    dreq_data     = 64'hDEAD_BEEF;
    run_txn("t2_d", 1'b1, 64'h55);
    dreq_valid = 1'b0;
    check("t2_d_wr", bus_is_write, 1'b1);
    check("t2_d_size", bus_size, 3'd2);
    check("t2_d_addr", bus_addr, 64'h8000_1000);
    check("t2_d_strb", bus_strobe, 8'h0F);
    check("t2_d_data", bus_data, 64'hDEAD_BEEF);
    run_txn("t2_i", 1'b0, 64'h66);
    check("t2_i_addr", bus_addr, 64'h8000_0040);
    check("t2_i_wr", bus_is_write, 1'b0);
    check("t2_i_size", bus_size, 3'd3);
    check("t2_i_strb", bus_strobe, 8'h00);
    check("t2_i_data", bus_data, 64'h0);
    ireq_valid = 1'b0;

    // Starvation guard: four contested load grants, then fetch, then load again.
    ireq_valid    = 1'b1;
    dreq_valid    = 1'b1;
    dreq_is_write = 1'b0;
    dreq_size     = 3'd3;
    dreq_addr     = 64'h8000_2000;
    dreq_strobe   = 8'h00;
    for (int g = 0; g < 6; g++) begin
      run_txn($sformatf("t3_g%0d", g), (g == 4) ? 1'b0 : 1'b1, 64'(g));
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;

    // Latched fields must ignore requester changes while busy.
    dreq_valid = 1'b1;
    dreq_addr  = 64'h1000_0000;
    dreq_data  = 64'hAAAA_0000;
    @(negedge clk);
    check("t4_idle_bv", bus_valid, 1'b0);
    step();
    @(negedge clk);
    check("t4_bv", bus_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      dreq_addr = dreq_addr + 64'h8;
      dreq_data = dreq_data ^ 64'hFFFF;
      @(negedge clk);
      check($sformatf("t4_addr%0d", i), bus_addr, 64'h1000_0000);
      check($sformatf("t4_data%0d", i), bus_data, 64'hAAAA_0000);
    end
    step();
    bus_resp_ready = 1'b1;
    @(negedge clk);
    check("t4_dresp", dresp_ready, 1'b1);
    step();
    bus_resp_ready = 1'b0;
    dreq_valid     = 1'b0;

    // Reset two cycles into a store aborts it; fetch then wins after one cycle.
    dreq_valid    = 1'b1;
    dreq_is_write = 1'b1;
    dreq_addr     = 64'h2000_0000;
    @(negedge clk);
    check("t5_idle_bv", bus_valid, 1'b0);
    step();
    @(negedge clk);
    check("t5_bv", bus_valid, 1'b1);
    step();
    #2;
    reset          = 1'b1;
    bus_resp_ready = 1'b1;
    #1;
    check("t5_rst_bv", bus_valid, 1'b0);
    check("t5_rst_dresp", dresp_ready, 1'b0);
    check("t5_rst_addr", bus_addr, 64'h0);
    step();
    reset          = 1'b0;
    bus_resp_ready = 1'b0;
    dreq_valid     = 1'b0;
    ireq_valid     = 1'b1;
    ireq_addr      = 64'h8000_0100;
    run_txn("t5_i", 1'b0, 64'h77);
    check("t5_i_addr", bus_addr, 64'h8000_0100);
    ireq_valid = 1'b0;

    // Spurious response while idle.
    bus_resp_ready = 1'b1;
    bus_resp_data  = 64'h99;
    @(negedge clk);
    check("t6_iresp", iresp_ready, 1'b0);
    check("t6_dresp", dresp_ready, 1'b0);
    step();
    bus_resp_ready = 1'b0;
    @(negedge clk);
    check("t6_bv", bus_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter sharing the single core-side memory bus between instruction fetch (ireq) and load/store (dreq) in the RV64 pipeline.
- Latches the winning request, holds the bus until the downstream response handshake completes, and routes the response back to the owner.
- Fixed priority to dreq, with a starvation guard that forces an ifetch grant after a bounded run of dreq grants.

Parameters:
- STARVE_LIMIT, 4: consecutive contested dreq grants allowed before ifetch is forced; range 1..15.
- XLEN, 64: address and data width; tied to common::XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request; held high until iresp_ready
- ireq_addr  in  64  fetch address
- iresp_ready  out  1  fetch response strobe
- iresp_data  out  64  fetch response data
- dreq_valid  in  1  load/store request; held high until dresp_ready
- dreq_is_write  in  1  1 = store
- dreq_size  in  3  log2 of access bytes (0..3)
- dreq_addr  in  64  data address
- dreq_strobe  in  8  byte enables, stores only
- dreq_data  in  64  store data
- dresp_ready  out  1  load/store response strobe
- dresp_data  out  64  load response data
- bus_valid  out  1  downstream request valid
- bus_is_write, bus_size, bus_addr, bus_strobe, bus_data  out  1/3/64/8/64  latched request fields
- bus_resp_ready  in  1  downstream response strobe
- bus_resp_data  in  64  downstream response data
- grant_d  out  1  current or last owner: 1 = dreq, 0 = ireq (observability)

Behaviour:
- States: IDLE, BUSY. Reset value: IDLE, bus_valid=0, all latched bus fields 0, grant_d=0, starve_cnt=0. iresp_ready and dresp_ready are 0 during reset.
- IDLE: if either valid is set, the arbiter picks a winner, latches its fields into the bus registers, sets grant_d, and moves to BUSY on the next edge. bus_valid is registered and rises in the cycle after the request is first seen, giving one cycle of arbitration latency.
- Selection:
  - Only ireq valid: ireq wins.
  - Only dreq valid: dreq wins.
  - Both valid: dreq wins unless starve_cnt == STARVE_LIMIT, in which case ireq wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a dreq grant made while ireq_valid=1.
  - Clears on any ireq grant.
  - Unchanged on an uncontested dreq grant.
- Fields for an ireq grant: is_write=0, size=3, strobe=0, data=0, addr=ireq_addr.
- BUSY: bus_valid=1 and bus fields stay stable regardless of requester inputs.
  - When bus_resp_ready=1, the owner's resp_ready is driven combinationally in the same cycle. The other requester's resp_ready stays 0.
  - On the next edge the state returns to IDLE and bus_valid=0.
- iresp_data and dresp_data both carry bus_resp_data unconditionally; the data is only meaningful with the matching ready strobe.
- Back-to-back: the response arrives in cycle k, the state is IDLE in cycle k+1 (re-arbitration), and the earliest next bus_valid is in cycle k+2. The bus is never re-granted in the response cycle.
- A requester that drops valid while BUSY is a protocol violation. The transaction still completes and its ready pulse is still emitted.
- bus_resp_ready while IDLE is ignored; no ready strobe is produced.
- Reset asserted mid-transaction aborts immediately: state IDLE, bus_valid=0, starve_cnt=0. The downstream bus must tolerate a dropped request.
- Requests arriving while BUSY wait; they are not queued beyond their own held valid.

Test Plan:
- Single fetch: ireq_valid=1, addr=0x80000000; bus_resp_ready pulses 3 cycles after bus_valid with data 0x00000013_00000093 -> bus_valid rises in cycle 1 with bus_addr=0x80000000, bus_is_write=0, bus_size=3; iresp_ready=1 with matching data in the pulse cycle; dresp_ready stays 0.
- Simultaneous requests: both valid in cycle 0, dreq a store (addr 0x80001000, strobe 0x0F, data 0xDEADBEEF, size 2) -> dreq served first with exact latched fields; ireq served next, bus_valid re-rising 2 cycles after dresp_ready.
- Starvation: ireq held high while dreq re-asserts immediately after each response, STARVE_LIMIT=4 -> 4 dreq grants, 5th grant to ireq (grant_d=0), then starve_cnt=0 and dreq wins again.
- Field stability: after a dreq grant, change dreq_addr/data every cycle while BUSY -> bus_* outputs unchanged until completion.
- Reset mid-BUSY: assert reset 2 cycles into a dreq transaction -> bus_valid=0 asynchronously, no dresp_ready; after release with ireq valid, the next grant goes to ireq in 1 cycle.
- Spurious response: bus_resp_ready=1 while IDLE -> no iresp_ready or dresp_ready, state stays IDLE.
